// File: rtl/freq_sched.sv
// freq_sched: per-frame tone scheduler for the first-stage frequency selector.
// Walks a programmable ascending table of FFT bin numbers against the incoming
// k stream and emits a select strobe plus tone slot index for every matched bin.
// Optional build macro: FREQ_SCHED_MISS_CNT_EN enables missed-tone accounting;
// without it miss_count is tied to zero and only the pointer advance remains.
module freq_sched #(
  parameter int N_TONES   = 128,
  parameter int K_WIDTH   = 14,
  parameter int IDX_WIDTH = 7
) (
  input  logic                 dev_clk,
  input  logic                 dev_rstn,
  input  logic                 cfg_we,
  input  logic [IDX_WIDTH-1:0] cfg_addr,
  input  logic [K_WIDTH-1:0]   cfg_k,
  input  logic [IDX_WIDTH:0]   cfg_num,
  input  logic                 enable,
  input  logic [K_WIDTH-1:0]   k_in,
  input  logic                 valid_in,
  input  logic                 frame_last,
  output logic                 sel_valid,
  output logic [IDX_WIDTH-1:0] sel_index,
  output logic                 frame_done,
  output logic [15:0]          frame_count,
  output logic [15:0]          miss_count,
  output logic                 busy,
  output logic                 cfg_err
);

  localparam int PW = IDX_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = {{IDX_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        w_ptr_nxt;
  logic [PW-1:0]        r_num;
  logic [K_WIDTH-1:0]   r_tab [N_TONES];
  logic                 r_sel_valid;
  logic [IDX_WIDTH-1:0] r_sel_index;
  logic                 r_frame_done;
  logic [15:0]          r_frame_count;
  logic                 r_busy;
  logic                 r_cfg_err;

  logic [PW-1:0]        w_ptr_eff;
  logic [PW-1:0]        w_ptr_adv;
  logic [K_WIDTH-1:0]   w_tab_k;
  logic                 w_scan;
  logic                 w_active;
  logic                 w_hit;
  logic                 w_skip;
  logic                 w_last;
  logic                 w_start;

  // Tone table: writable only while idle, contents deliberately not reset
  always_ff @(posedge dev_clk) begin
    if (dev_rstn && cfg_we && (r_state == ST_IDLE)) begin
      r_tab[cfg_addr] <= cfg_k;
    end
  end

  // Beat evaluation: a beat seen in DONE is the first beat of the next frame, so it uses ptr 0
  always_comb begin
    w_ptr_eff = (r_state == ST_DONE) ? PTR_ZERO : r_ptr;
    w_scan    = (r_state == ST_SCAN) || ((r_state == ST_DONE) && enable);
    w_active  = w_scan && valid_in && (w_ptr_eff < r_num);
    w_tab_k   = r_tab[w_ptr_eff[IDX_WIDTH-1:0]];
    w_hit     = w_active && (k_in == w_tab_k);
    w_skip    = w_active && (k_in > w_tab_k);
    w_ptr_adv = (w_hit || w_skip) ? (w_ptr_eff + PTR_ONE) : w_ptr_eff;
    w_last    = w_scan && valid_in && frame_last;
    w_start   = (r_state == ST_IDLE) && enable;
  end

  // Next-state and pointer update for the frame walker
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        w_ptr_nxt = PTR_ZERO;
        if (enable) begin
          w_state_nxt = ST_ARM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARM: begin
        w_ptr_nxt = PTR_ZERO;
        if (valid_in && frame_last) begin
          w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_ARM;
        end
      end
      ST_SCAN: begin
        if (w_last) begin
          w_ptr_nxt   = PTR_ZERO;
          w_state_nxt = ST_DONE;
        end else begin
          w_ptr_nxt   = w_ptr_adv;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_DONE: begin
        if (!enable) begin
          w_ptr_nxt   = PTR_ZERO;
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_ptr_nxt   = PTR_ZERO;
          w_state_nxt = ST_DONE;
        end else begin
          w_ptr_nxt   = w_ptr_adv;
          w_state_nxt = ST_SCAN;
        end
      end
      default: begin
        w_ptr_nxt   = PTR_ZERO;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs
  always_ff @(posedge dev_clk) begin
    if (!dev_rstn) begin
      r_state       <= ST_IDLE;
      r_ptr         <= PTR_ZERO;
      r_num         <= PTR_ZERO;
      r_sel_valid   <= 1'b0;
      r_sel_index   <= {IDX_WIDTH{1'b0}};
      r_frame_done  <= 1'b0;
      r_frame_count <= 16'h0000;
      r_busy        <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_sel_valid  <= w_hit;
      r_frame_done <= (r_state == ST_DONE);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_cfg_err    <= cfg_we && (r_state != ST_IDLE);
      if (w_hit) begin
        r_sel_index <= w_ptr_eff[IDX_WIDTH-1:0];
      end
      if (w_start) begin
        r_num         <= cfg_num;
        r_frame_count <= 16'h0000;
      end else if (r_state == ST_DONE) begin
        r_frame_count <= r_frame_count + 16'h0001;
      end
    end
  end

`ifdef FREQ_SCHED_MISS_CNT_EN
  logic [PW:0]   w_miss_add;
  logic [16:0]   w_miss_sum;
  logic [15:0]   r_miss_count;

  // Missed tones this beat: one for a skipped slot, plus all unvisited slots at frame end
  always_comb begin
    w_miss_add = {{PW{1'b0}}, w_skip};
    if (w_last) begin
      w_miss_add = w_miss_add + {1'b0, (r_num - w_ptr_adv)};
    end else begin
      w_miss_add = w_miss_add;
    end
    w_miss_sum = {1'b0, r_miss_count} + {{(16 - PW){1'b0}}, w_miss_add};
  end

  // Saturating miss counter, cleared when a run starts
  always_ff @(posedge dev_clk) begin
    if (!dev_rstn) begin
      r_miss_count <= 16'h0000;
    end else if (w_start) begin
      r_miss_count <= 16'h0000;
    end else if (w_miss_sum[16]) begin
      r_miss_count <= 16'hFFFF;
    end else begin
      r_miss_count <= w_miss_sum[15:0];
    end
  end

  assign miss_count = r_miss_count;
`else
  assign miss_count = 16'h0000;
`endif

  assign sel_valid   = r_sel_valid;
  assign sel_index   = r_sel_index;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign busy        = r_busy;
  assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_freq_sched.sv
// tb_freq_sched: directed bench for freq_sched with hand-computed expectations.
module tb_freq_sched;
  localparam int KW = 14;
  localparam int IW = 7;
`ifdef FREQ_SCHED_MISS_CNT_EN
  localparam int MISS_EN = 1;
`else
  localparam int MISS_EN = 0;
`endif

  logic          dev_clk = 1'b0;
  logic          dev_rstn = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [KW-1:0] cfg_k = '0;
  logic [IW:0]   cfg_num = '0;
  logic          enable = 1'b0;
  logic [KW-1:0] k_in = '0;
  logic          valid_in = 1'b0;
  logic          frame_last = 1'b0;
  logic          sel_valid;
  logic [IW-1:0] sel_index;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic [15:0]   miss_count;
  logic          busy;
  logic          cfg_err;

  freq_sched dut (
    .dev_clk(dev_clk), .dev_rstn(dev_rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_k(cfg_k), .cfg_num(cfg_num), .enable(enable), .k_in(k_in),
    .valid_in(valid_in), .frame_last(frame_last), .sel_valid(sel_valid),
    .sel_index(sel_index), .frame_done(frame_done), .frame_count(frame_count),
    .miss_count(miss_count), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 dev_clk = ~dev_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int k_at_edge = 0;
  int sel_idx_q[$];
  int sel_k_q[$];
  int fd_cnt = 0;
  int sel_cyc = 0;
  int fd_cyc = 0;

  // Capture the k value the DUT samples on each rising edge
  always @(posedge dev_clk) begin
    cyc <= cyc + 1;
    k_at_edge <= int'(k_in);
  end

  // Log selections (with the k that caused them one edge earlier) and frame_done pulses
  always @(negedge dev_clk) begin
    if (sel_valid) begin
      sel_idx_q.push_back(int'(sel_index));
      sel_k_q.push_back(k_at_edge);
      sel_cyc = cyc;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic beat(input int k, input logic last);
    @(posedge dev_clk); #1;
    k_in = k[KW-1:0];
    valid_in = 1'b1;
    frame_last = last;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge dev_clk); #1;
      valid_in = 1'b0;
      frame_last = 1'b0;
    end
  endtask

  task automatic run_frame(input int first, input int last, input int skip, input int drop_at);
    for (int k = first; k <= last; k++) begin
      if (k != skip) begin
        if (k == drop_at) enable = 1'b0;
        beat(k, (k == last));
      end
    end
  endtask

  task automatic cfg_write(input int addr, input int k);
    @(posedge dev_clk); #1;
    cfg_we = 1'b1;
    cfg_addr = addr[IW-1:0];
    cfg_k = k[KW-1:0];
    @(posedge dev_clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input int num, input logic align);
    @(posedge dev_clk); #1;
    cfg_num = num[IW:0];
    enable = 1'b1;
    if (align) beat(0, 1'b1);
  endtask

  task automatic clear_log();
    sel_idx_q.delete();
    sel_k_q.delete();
    fd_cnt = 0;
  endtask

  task automatic test_reset();
    dev_rstn = 1'b0;
    repeat (3) @(posedge dev_clk);
    #1;
    n_vec++; if (sel_valid !== 1'b0) begin n_err++; $display("FAIL reset_sel_valid got %0d want 0", sel_valid); end
    n_vec++; if (sel_index !== 7'd0) begin n_err++; $display("FAIL reset_sel_index got %0d want 0", sel_index); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %0d want 0", frame_done); end
    n_vec++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
    n_vec++; if (miss_count !== 16'd0) begin n_err++; $display("FAIL reset_miss_count got %0d want 0", miss_count); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0d want 0", busy); end
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err got %0d want 0", cfg_err); end
    dev_rstn = 1'b1;
  endtask

  task automatic test_basic();
    int ei[3] = '{0, 1, 2};
    int ek[3] = '{5, 9, 20};
    cfg_write(0, 5); cfg_write(1, 9); cfg_write(2, 20);
    start_run(3, 1'b1);
    clear_log();
    run_frame(0, 31, -1, -1);
    idle(3);
    n_vec++; if (sel_idx_q.size() !== 3) begin n_err++; $display("FAIL basic_sel_count got %0d want 3", sel_idx_q.size()); end
    for (int i = 0; i < 3 && i < sel_idx_q.size(); i++) begin
      n_vec++; if (sel_idx_q[i] !== ei[i] || sel_k_q[i] !== ek[i]) begin
        n_err++; $display("FAIL basic_sel[%0d] got idx %0d k %0d want idx %0d k %0d", i, sel_idx_q[i], sel_k_q[i], ei[i], ek[i]);
      end
    end
    n_vec++; if (fd_cnt !== 1) begin n_err++; $display("FAIL basic_frame_done got %0d want 1", fd_cnt); end
    n_vec++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL basic_frame_count got %0d want 1", frame_count); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %0d want 1", busy); end
  endtask

  task automatic test_miss();
    clear_log();
    run_frame(0, 31, 9, -1);
    idle(3);
    n_vec++; if (sel_idx_q.size() !== 2) begin n_err++; $display("FAIL miss_sel_count got %0d want 2", sel_idx_q.size()); end
    if (sel_idx_q.size() == 2) begin
      n_vec++; if (sel_idx_q[0] !== 0 || sel_idx_q[1] !== 2) begin
        n_err++; $display("FAIL miss_sel_idx got %0d,%0d want 0,2", sel_idx_q[0], sel_idx_q[1]);
      end
    end
    n_vec++; if (int'(miss_count) !== MISS_EN) begin n_err++; $display("FAIL miss_count_skip got %0d want %0d", miss_count, MISS_EN); end
    // Short frame: slot 2 (k=20) is never reached, counted at frame end
    clear_log();
    run_frame(0, 15, -1, -1);
    idle(3);
    n_vec++; if (sel_idx_q.size() !== 2) begin n_err++; $display("FAIL short_sel_count got %0d want 2", sel_idx_q.size()); end
    n_vec++; if (int'(miss_count) !== 2 * MISS_EN) begin n_err++; $display("FAIL miss_count_eof got %0d want %0d", miss_count, 2 * MISS_EN); end
    n_vec++; if (frame_count !== 16'd3) begin n_err++; $display("FAIL miss_frame_count got %0d want 3", frame_count); end
  endtask

  task automatic test_cfg_lockout();
    cfg_write(0, 7);
    n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL lockout_cfg_err got %0d want 1", cfg_err); end
    @(posedge dev_clk); #1;
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL lockout_cfg_err_pulse got %0d want 0", cfg_err); end
    clear_log();
    run_frame(0, 31, -1, -1);
    idle(3);
    n_vec++; if (sel_k_q.size() !== 3) begin n_err++; $display("FAIL lockout_sel_count got %0d want 3", sel_k_q.size()); end
    else begin
      n_vec++; if (sel_k_q[0] !== 5 || sel_idx_q[0] !== 0) begin
        n_err++; $display("FAIL lockout_table got k %0d idx %0d want k 5 idx 0", sel_k_q[0], sel_idx_q[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ei[6] = '{0, 1, 2, 0, 1, 2};
    int ek[6] = '{5, 9, 20, 5, 9, 20};
    clear_log();
    run_frame(0, 31, -1, -1);
    run_frame(5, 31, -1, -1);
    idle(3);
    n_vec++; if (sel_idx_q.size() !== 6) begin n_err++; $display("FAIL b2b_sel_count got %0d want 6", sel_idx_q.size()); end
    for (int i = 0; i < 6 && i < sel_idx_q.size(); i++) begin
      n_vec++; if (sel_idx_q[i] !== ei[i] || sel_k_q[i] !== ek[i]) begin
        n_err++; $display("FAIL b2b_sel[%0d] got idx %0d k %0d want idx %0d k %0d", i, sel_idx_q[i], sel_k_q[i], ei[i], ek[i]);
      end
    end
    n_vec++; if (fd_cnt !== 2) begin n_err++; $display("FAIL b2b_frame_done got %0d want 2", fd_cnt); end
    n_vec++; if (frame_count !== 16'd6) begin n_err++; $display("FAIL b2b_frame_count got %0d want 6", frame_count); end
  endtask

  task automatic test_enable_drop();
    clear_log();
    run_frame(0, 31, -1, 10);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL drop_busy_mid got %0d want 1", busy); end
    idle(3);
    n_vec++; if (sel_idx_q.size() !== 3) begin n_err++; $display("FAIL drop_sel_count got %0d want 3", sel_idx_q.size()); end
    n_vec++; if (fd_cnt !== 1) begin n_err++; $display("FAIL drop_frame_done got %0d want 1", fd_cnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy_end got %0d want 0", busy); end
    n_vec++; if (frame_count !== 16'd7) begin n_err++; $display("FAIL drop_frame_count got %0d want 7", frame_count); end
    n_vec++; if (int'(miss_count) !== 2 * MISS_EN) begin n_err++; $display("FAIL drop_miss_count got %0d want %0d", miss_count, 2 * MISS_EN); end
  endtask

  task automatic test_boundary();
    cfg_write(0, 31);
    start_run(1, 1'b1);
    clear_log();
    run_frame(0, 31, -1, 20);
    idle(4);
    n_vec++; if (sel_idx_q.size() !== 1) begin n_err++; $display("FAIL bnd_sel_count got %0d want 1", sel_idx_q.size()); end
    else begin
      n_vec++; if (sel_idx_q[0] !== 0 || sel_k_q[0] !== 31) begin
        n_err++; $display("FAIL bnd_sel got idx %0d k %0d want idx 0 k 31", sel_idx_q[0], sel_k_q[0]);
      end
    end
    n_vec++; if (fd_cnt !== 1 || fd_cyc !== sel_cyc + 1) begin
      n_err++; $display("FAIL bnd_done_timing got cnt %0d cyc %0d want cnt 1 cyc %0d", fd_cnt, fd_cyc, sel_cyc + 1);
    end
    n_vec++; if (miss_count !== 16'd0) begin n_err++; $display("FAIL bnd_miss_count got %0d want 0", miss_count); end
    // Empty table: frames still counted, nothing selected
    start_run(0, 1'b1);
    clear_log();
    run_frame(0, 31, -1, 20);
    idle(4);
    n_vec++; if (sel_idx_q.size() !== 0) begin n_err++; $display("FAIL num0_sel_count got %0d want 0", sel_idx_q.size()); end
    n_vec++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL num0_frame_count got %0d want 1", frame_count); end
    n_vec++; if (fd_cnt !== 1) begin n_err++; $display("FAIL num0_frame_done got %0d want 1", fd_cnt); end
  endtask

  task automatic test_align_reset();
    cfg_write(0, 5);
    start_run(3, 1'b0);
    clear_log();
    run_frame(10, 31, -1, -1);
    idle(3);
    n_vec++; if (sel_idx_q.size() !== 0) begin n_err++; $display("FAIL align_sel_count got %0d want 0", sel_idx_q.size()); end
    n_vec++; if (fd_cnt !== 0) begin n_err++; $display("FAIL align_frame_done got %0d want 0", fd_cnt); end
    clear_log();
    run_frame(0, 31, -1, -1);
    idle(3);
    n_vec++; if (sel_idx_q.size() !== 3) begin n_err++; $display("FAIL align_next_sel_count got %0d want 3", sel_idx_q.size()); end
    n_vec++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL align_frame_count got %0d want 1", frame_count); end
    // Reset in the middle of a scanned frame
    clear_log();
    for (int k = 0; k <= 12; k++) beat(k, 1'b0);
    @(posedge dev_clk); #1;
    dev_rstn = 1'b0; valid_in = 1'b0; enable = 1'b0;
    @(posedge dev_clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %0d want 0", busy); end
    n_vec++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL rst_mid_frame_count got %0d want 0", frame_count); end
    n_vec++; if (sel_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_sel_valid got %0d want 0", sel_valid); end
    dev_rstn = 1'b1;
    idle(4);
    n_vec++; if (fd_cnt !== 0) begin n_err++; $display("FAIL rst_mid_frame_done got %0d want 0", fd_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_miss();
    test_cfg_lockout();
    test_back_to_back();
    test_enable_drop();
    test_boundary();
    test_align_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
